// File: rtl/sobol_sched.sv
// sobol_sched: run controller and round-robin two-stream arbiter for the sobolflex dual-index counter.
// Ports: iClk/iRstN clock and async active-low reset. iStart launches a run from IDLE; iAbort ends a run in RUN.
// iReq0/iReq1 sample requests. oGnt0/oGnt1 are combinational grants.
// oSel/oLsz/oLszVld are the registered stream id and lowest-zero position of the granted index.
// oClr is the counter clear pulse. oExh holds the per-stream exhausted flags.
// oBusy is high when the FSM is not IDLE. oDone pulses once when a run completes.
// Build option: define SOBOL_SCHED_WRAP_EN to make indices wrap.
// In that build oDone pulses with each wrapping sample and the run never self-terminates.
module sobol_sched #(
  parameter int BITWIDTH = 4,
  parameter int LSZW = 3
) (
  input  logic            iClk,
  input  logic            iRstN,
  input  logic            iStart,
  input  logic            iAbort,
  input  logic            iReq0,
  input  logic            iReq1,
  output logic            oGnt0,
  output logic            oGnt1,
  output logic            oSel,
  output logic            oClr,
  output logic            oLszVld,
  output logic [LSZW-1:0] oLsz,
  output logic [1:0]      oExh,
  output logic            oBusy,
  output logic            oDone
);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} stateT;
  stateT state, nextState;
  logic [BITWIDTH-1:0] idx0, idx1, gIdx;
  logic [LSZW-1:0] lszNext;
  logic rrLast, inRun, abort, elig0, elig1, gnt, last, clear;
  assign inRun = state == RUN;
  assign abort = inRun & iAbort;
  assign elig0 = iReq0 & ~oExh[0];
  assign elig1 = iReq1 & ~oExh[1];
  // rrLast holds the id of the last granted stream, so a tie goes to the other stream
  assign oGnt0 = inRun & ~iAbort & elig0 & (~elig1 | rrLast);
  assign oGnt1 = inRun & ~iAbort & elig1 & (~elig0 | ~rrLast);
  assign gnt = oGnt0 | oGnt1;
  assign gIdx = oGnt1 ? idx1 : idx0;
  assign last = &gIdx;
  assign oBusy = state != IDLE;
  assign clear = (state == IDLE && iStart) || abort;
  // lowest zero bit of the pre-increment index; an all-ones index maps to BITWIDTH
  always_comb begin
    lszNext = LSZW'(BITWIDTH);
    for (int i = BITWIDTH - 1; i >= 0; i--)
      if (!gIdx[i]) lszNext = LSZW'(i);
  end
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = iStart ? CLEAR : IDLE;
      CLEAR:   nextState = RUN;
`ifdef SOBOL_SCHED_WRAP_EN
      RUN:     nextState = iAbort ? IDLE : RUN;
`else
      RUN:     nextState = iAbort ? IDLE : (&oExh ? DONE : RUN);
`endif
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state   <= IDLE;
      idx0    <= '0;
      idx1    <= '0;
      oExh    <= '0;
      rrLast  <= 1'b1;
      oSel    <= 1'b0;
      oClr    <= 1'b0;
      oLszVld <= 1'b0;
      oLsz    <= '0;
      oDone   <= 1'b0;
    end else begin
      state   <= nextState;
      oClr    <= clear;
      oLszVld <= gnt;
      if (gnt) begin
        oSel   <= oGnt1;
        oLsz   <= lszNext;
        rrLast <= oGnt1;
      end
      if (clear) begin
        idx0 <= '0;
        idx1 <= '0;
        oExh <= '0;
      end else begin
`ifdef SOBOL_SCHED_WRAP_EN
        if (oGnt0) idx0 <= idx0 + 1'b1;
        if (oGnt1) idx1 <= idx1 + 1'b1;
`else
        // the final index holds and marks the stream exhausted instead of wrapping
        if (oGnt0) begin
          if (last) oExh[0] <= 1'b1;
          else idx0 <= idx0 + 1'b1;
        end
        if (oGnt1) begin
          if (last) oExh[1] <= 1'b1;
          else idx1 <= idx1 + 1'b1;
        end
`endif
      end
`ifdef SOBOL_SCHED_WRAP_EN
      oDone <= gnt & last;
`else
      oDone <= nextState == DONE;
`endif
    end
  end
endmodule

// File: doc/sobol_sched.md
Name: sobol_sched

Overview:
- Run controller and two-stream arbiter for the sobolflex dual-index counter (two counters, shared increment path, selected per cycle).
- Starts a Sobol sequence run and clears the counters.
- Round-robins a single shared generation slot between two requesters.
- Tracks each stream's sample index and emits the select, clear and least-significant-zero (LSZ) position that drive direction-vector lookup and XOR accumulation.

Parameters:
- BITWIDTH, 4, width of each stream's sample index; sequence length SEQLEN = 2^BITWIDTH.
- LSZW, 3, width of oLsz; must satisfy 2^LSZW > BITWIDTH.

Ports:
- iClk  in  1  clock
- iRstN  in  1  asynchronous reset, active low
- iStart  in  1  start a run (sampled in IDLE only)
- iAbort  in  1  terminate current run
- iReq0  in  1  stream 0 sample request
- iReq1  in  1  stream 1 sample request
- oGnt0  out  1  stream 0 granted this cycle (combinational)
- oGnt1  out  1  stream 1 granted this cycle (combinational)
- oSel  out  1  registered stream id of last grant; drives counter select
- oClr  out  1  registered counter clear pulse
- oLszVld  out  1  registered; oSel/oLsz valid
- oLsz  out  LSZW  registered LSZ position of granted stream's index
- oExh  out  2  per-stream exhausted flags
- oBusy  out  1  state != IDLE
- oDone  out  1  one-cycle run-complete pulse

Behaviour:
- Async reset: all registered outputs 0, idx0 = idx1 = 0, oExh = 0, rr_last = 1 (stream 0 wins first tie), state IDLE.
- States: IDLE, CLEAR, RUN, DONE.
  - IDLE: iStart -> CLEAR.
  - CLEAR: one cycle, oClr = 1, indices and oExh zeroed -> RUN.
  - RUN: both oExh set -> DONE; iAbort -> IDLE.
  - DONE: one cycle, oDone = 1 -> IDLE.
- Grants only in RUN, at most one per cycle.
  - Eligible: iReqN = 1 and oExh[N] = 0.
  - One eligible stream: it is granted.
  - Both eligible: grant the stream != rr_last.
  - rr_last updates only on a grant.
- Handshake:
  - Requester holds iReqN until oGntN.
  - A grant consumes exactly one sample.
  - Dropping the request without a grant is legal.
- On a grant to stream N:
  - Next cycle: oLszVld = 1, oSel = N, oLsz = index of lowest 0 bit of idxN (pre-increment). idxN all-ones -> oLsz = BITWIDTH.
  - idxN increments.
  - If idxN was SEQLEN-1: oExh[N] set, idxN holds.
- No grant: oLszVld = 0; oSel and oLsz hold their last values.
- Latency: grant -> oLszVld is 1 cycle.
- iAbort:
  - Has priority over a grant in the same cycle; no grant issues.
  - Next cycle: IDLE, indices and oExh cleared, oClr = 1 for one cycle, oLszVld = 0, no oDone.
- iStart outside IDLE: ignored.
- iAbort outside RUN: ignored.
- Async reset mid-run: immediate return to reset state; no oDone.
- Last sample and exhaustion in the same cycle: that sample's oLszVld and the transition to DONE are both honoured. oDone asserts the cycle after the final oLszVld.

Optional Feature:
- Macro: SOBOL_SCHED_WRAP_EN.
- Defined:
  - Stream index at SEQLEN-1 wraps to 0 on grant; oExh stays 0.
  - oDone pulses together with each wrapping sample's oLszVld.
  - FSM leaves RUN only via iAbort or reset; DONE state unused.
- Undefined: exhaustion and DONE behaviour as specified above.

Test Plan:
1. Reset then idle with requests and no iStart -> all outputs 0, no grants, oBusy = 0.
2. iStart, iReq0 held, iReq1 = 0 (BITWIDTH = 4):
   - oClr pulse, then 16 grants to stream 0.
   - oLsz = 0,1,0,2,0,1,0,3,0,1,0,2,0,1,0,4.
   - oExh = 2'b01; no oDone.
   - Then iReq1 held: 16 grants to stream 1, oExh = 2'b11, oDone pulse one cycle after the last oLszVld, then oBusy = 0.
3. Both requests held after start:
   - Grants 0,1,0,1,...; oSel = 0,1,0,1.
   - oLsz = 0,0,1,1,0,0,2,2.
   - 32 grants total, then oDone.
4. iAbort asserted together with a pending grant after 5 samples:
   - No grant that cycle.
   - Next cycle: IDLE, oClr = 1, oExh = 0.
   - A restart yields oLsz starting at 0.
5. iRstN low for 1 cycle mid-run (7 samples issued) -> outputs 0 immediately, no oDone, next run restarts from idx 0.
6. With SOBOL_SCHED_WRAP_EN, iReq0 held for 20 grants:
   - oLsz 16th = 4, then 0,1,0,2.
   - oDone pulses with the 16th sample; oExh stays 0.
